// File: rtl/soc_reset_sequencer.sv
// Staged SoC reset sequencer: lock filter, then ordered periph/mem/core release.
// Optional: define RESET_CAUSE_LOG_EN to record the last reset cause.
module soc_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_FILTER_CYCLES = 16,
  parameter int STAGE_DELAY        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       periph_rst,
  output logic       mem_rst,
  output logic       core_rst,
  output logic       rst_done,
  output logic [2:0] rst_cause
);

  localparam int MAXC =
    (LOCK_FILTER_CYCLES > STAGE_DELAY) ?
    LOCK_FILTER_CYCLES : STAGE_DELAY;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] LOCK_LAST =
    CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST =
    CW'(STAGE_DELAY - 1);

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    REL_PERIPH = 3'd1,
    REL_MEM    = 3'd2,
    REL_CORE   = 3'd3,
    RUN        = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_lock_cnt;
  logic [CW-1:0]          r_stage_cnt;

  logic r_periph_rst;
  logic r_mem_rst;
  logic r_core_rst;
  logic r_rst_done;

  logic w_pll_sync;
  logic w_abort_lock;
  logic w_abort_sw;
  logic w_abort;
  logic w_lock_hit;
  logic w_stage_hit;
  logic w_in_stage;

  logic w_periph_rst;
  logic w_mem_rst;
  logic w_core_rst;
  logic w_rst_done;

  assign w_pll_sync = r_sync[SYNC_STAGES-1];

  // Lock loss outranks a software request on the same edge.
  assign w_abort_lock = (r_state != HOLD) && !w_pll_sync;
  assign w_abort_sw   = (r_state != HOLD) && w_pll_sync
                        && sw_rst_req;
  assign w_abort      = w_abort_lock || w_abort_sw;

  assign w_lock_hit  = w_pll_sync && (r_lock_cnt == LOCK_LAST);
  assign w_stage_hit = (r_stage_cnt == STAGE_LAST);
  assign w_in_stage  = (r_state == REL_PERIPH)
                       || (r_state == REL_MEM);

  // Bring the asynchronous lock into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: filter lock in HOLD, step through releases.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD: begin
        if (w_lock_hit) begin
          w_state_nxt = REL_PERIPH;
        end
      end
      REL_PERIPH: begin
        if (w_abort) begin
          w_state_nxt = HOLD;
        end else if (w_stage_hit) begin
          w_state_nxt = REL_MEM;
        end
      end
      REL_MEM: begin
        if (w_abort) begin
          w_state_nxt = HOLD;
        end else if (w_stage_hit) begin
          w_state_nxt = RUN;
        end
      end
      REL_CORE: begin
        if (w_abort) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = HOLD;
      end
    endcase
  end

  // Lock filter and stage gap counters; both stop at their transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_cnt  <= '0;
      r_stage_cnt <= '0;
    end else begin
      if ((r_state == HOLD) && w_pll_sync && !w_lock_hit) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end else begin
        r_lock_cnt <= '0;
      end
      if (w_in_stage && (w_state_nxt == r_state)) begin
        r_stage_cnt <= r_stage_cnt + 1'b1;
      end else begin
        r_stage_cnt <= '0;
      end
    end
  end

  // Output decode from the state about to be entered.
  always_comb begin
    w_periph_rst = 1'b1;
    w_mem_rst    = 1'b1;
    w_core_rst   = 1'b1;
    w_rst_done   = 1'b0;
    case (w_state_nxt)
      HOLD: begin
        w_periph_rst = 1'b1;
      end
      REL_PERIPH: begin
        w_periph_rst = 1'b0;
      end
      REL_MEM: begin
        w_periph_rst = 1'b0;
        w_mem_rst    = 1'b0;
      end
      REL_CORE, RUN: begin
        w_periph_rst = 1'b0;
        w_mem_rst    = 1'b0;
        w_core_rst   = 1'b0;
        w_rst_done   = 1'b1;
      end
      default: begin
        w_periph_rst = 1'b1;
      end
    endcase
  end

  // Registered reset outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_periph_rst <= 1'b1;
      r_mem_rst    <= 1'b1;
      r_core_rst   <= 1'b1;
      r_rst_done   <= 1'b0;
    end else begin
      r_periph_rst <= w_periph_rst;
      r_mem_rst    <= w_mem_rst;
      r_core_rst   <= w_core_rst;
      r_rst_done   <= w_rst_done;
    end
  end

  assign periph_rst = r_periph_rst;
  assign mem_rst    = r_mem_rst;
  assign core_rst   = r_core_rst;
  assign rst_done   = r_rst_done;

`ifdef RESET_CAUSE_LOG_EN
  logic [2:0] r_cause;

  // Remember why the last full reset happened.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cause <= 3'b001;
    end else if (w_abort_lock) begin
      r_cause <= 3'b010;
    end else if (w_abort_sw) begin
      r_cause <= 3'b100;
    end
  end

  assign rst_cause = r_cause;
`else
  assign rst_cause = 3'b000;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Randomised and directed bench for soc_reset_sequencer.
// Reference: release timeline model (lock run length + time since release).
module tb_soc_reset_sequencer;

  localparam int SS = 2;
  localparam int LF = 16;
  localparam int SD = 8;

`ifdef RESET_CAUSE_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       periph_rst;
  logic       mem_rst;
  logic       core_rst;
  logic       rst_done;
  logic [2:0] rst_cause;

  soc_reset_sequencer #(
    .SYNC_STAGES(SS),
    .LOCK_FILTER_CYCLES(LF),
    .STAGE_DELAY(SD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .periph_rst(periph_rst),
    .mem_rst(mem_rst),
    .core_rst(core_rst),
    .rst_done(rst_done),
    .rst_cause(rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: pll history queue, consecutive-high run, time since release.
  bit       m_q[$];
  bit       m_run;
  int       m_cnt;
  int       m_t;
  bit [2:0] m_cause;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b expected %b",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit p, input bit s);
    bit ps;
    if (r) begin
      m_q.delete();
      for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
      m_run   = 1'b0;
      m_cnt   = 0;
      m_t     = 0;
      m_cause = 3'b001;
    end else begin
      ps = m_q[0];
      if (!m_run) begin
        if (ps) begin
          if (m_cnt == LF - 1) begin
            m_run = 1'b1;
            m_t   = 0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end else begin
          m_cnt = 0;
        end
      end else if (!ps) begin
        m_run   = 1'b0;
        m_cnt   = 0;
        m_cause = 3'b010;
      end else if (s) begin
        m_run   = 1'b0;
        m_cnt   = 0;
        m_cause = 3'b100;
      end else if (m_t < 2 * SD) begin
        m_t++;
      end
      void'(m_q.pop_front());
      m_q.push_back(p);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic p, m, c, d;
    logic [2:0] cs;
    p  = !m_run;
    m  = !(m_run && m_t >= SD);
    c  = !(m_run && m_t >= 2 * SD);
    d  = !c;
    cs = LOG ? m_cause : 3'b000;
    return {1'b0, p, m, c, d, cs};
  endfunction

  function automatic logic [7:0] dut_out();
    return {1'b0, periph_rst, mem_rst, core_rst,
            rst_done, rst_cause};
  endfunction

  // Drive at negedge, advance model on the edge, compare at next negedge.
  task automatic step(input bit r, input bit p, input bit s);
    reset      = r;
    pll_locked = p;
    sw_rst_req = s;
    @(posedge clk);
    model_edge(r, p, s);
    cyc++;
    @(negedge clk);
    chk("cycle", dut_out(), model_out());
  endtask

  logic [2:0] cz1;

  initial begin
    cz1        = LOG ? 3'b001 : 3'b000;
    reset      = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    @(negedge clk);

    // Power-on reset, lock steady.
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("reset_state", {4'b0, periph_rst, mem_rst,
        core_rst, rst_done}, 8'b0000_1110);
    chk("reset_cause", {5'b0, rst_cause}, {5'b0, cz1});
    for (int k = 1; k <= 34; k++) begin
      step(0, 1, 0);
      if (k == 17) chk("periph_e17", {7'b0, periph_rst}, 8'd1);
      if (k == 18) chk("periph_e18", {7'b0, periph_rst}, 8'd0);
      if (k == 25) chk("mem_e25", {7'b0, mem_rst}, 8'd1);
      if (k == 26) chk("mem_e26", {7'b0, mem_rst}, 8'd0);
      if (k == 33) chk("core_e33", {7'b0, core_rst}, 8'd1);
      if (k == 34) chk("done_e34", {6'b0, core_rst, rst_done},
                       8'b01);
    end
    chk("cause_run", {5'b0, rst_cause}, {5'b0, cz1});

    // Lock glitch during the filter restarts the count.
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int k = 1; k <= 44; k++) begin
      step(0, (k == 10) ? 1'b0 : 1'b1, 0);
      if (k == 27) chk("glitch_e27", {7'b0, periph_rst}, 8'd1);
      if (k == 28) chk("glitch_e28", {7'b0, periph_rst}, 8'd0);
      if (k == 44) chk("glitch_done", {7'b0, rst_done}, 8'd1);
    end

    // Software reset from RUN.
    step(0, 1, 1);
    chk("sw_assert", {4'b0, periph_rst, mem_rst,
        core_rst, rst_done}, 8'b0000_1110);
    chk("sw_cause", {5'b0, rst_cause},
        {5'b0, LOG ? 3'b100 : 3'b000});
    for (int k = 1; k <= 32; k++) begin
      step(0, 1, 0);
      if (k == 15) chk("sw_e15", {7'b0, periph_rst}, 8'd1);
      if (k == 16) chk("sw_e16", {7'b0, periph_rst}, 8'd0);
      if (k == 24) chk("sw_e24", {7'b0, mem_rst}, 8'd0);
      if (k == 32) chk("sw_e32", {7'b0, rst_done}, 8'd1);
    end

    // Lock loss while in REL_MEM.
    step(0, 1, 1);
    for (int k = 1; k <= 28; k++) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("ll_e2", {6'b0, mem_rst, core_rst}, 8'b01);
    step(0, 0, 0);
    chk("ll_e3", {4'b0, periph_rst, mem_rst,
        core_rst, rst_done}, 8'b0000_1110);
    chk("ll_cause", {5'b0, rst_cause},
        {5'b0, LOG ? 3'b010 : 3'b000});
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 1, 0);
    chk("relock_hold", {7'b0, periph_rst}, 8'd1);
    for (int k = 1; k <= 30; k++) step(0, 1, 0);

    // Lock loss and sw request on the same edge; sw in HOLD ignored.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("both_cause", {5'b0, rst_cause},
        {5'b0, LOG ? 3'b010 : 3'b000});
    for (int k = 0; k < 3; k++) step(0, 0, 1);
    chk("hold_sw", {4'b0, periph_rst, mem_rst, core_rst,
        rst_done}, 8'b0000_1110);
    chk("hold_sw_cause", {5'b0, rst_cause},
        {5'b0, LOG ? 3'b010 : 3'b000});
    for (int k = 1; k <= 40; k++) step(0, 1, 0);

    // Reset in REL_PERIPH.
    step(0, 1, 1);
    for (int k = 1; k <= 18; k++) step(0, 1, 0);
    chk("rp_periph", {7'b0, periph_rst}, 8'd0);
    step(1, 1, 0);
    chk("rp_reset", {4'b0, periph_rst, mem_rst,
        core_rst, rst_done}, 8'b0000_1110);
    chk("rp_cause", {5'b0, rst_cause}, {5'b0, cz1});

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 299) != 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
